decode_assist_unit: RTL and testbench

Decode-stage helper for the five-stage MIPS-subset pipeline. It combines three functions: an immediate extender, a branch comparator, and a synthesizable instruction disassembler. The disassembler classifies the instruction and breaks out its fields and target addresses. The block also holds a one-entry trace register (PC plus instruction) that the pipeline uses for debug and commit tracing. It sits beside the register-file read logic in the Decode stage.

---
 rtl/decode_assist_unit_if.sv | 37 +++
 rtl/decode_assist_unit.sv | 115 +++++++++++
 tb/tb_decode_assist_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_assist_unit_if.sv
// Decode-assist signal bundle: extender, comparator, disassembler and trace outputs.
// The master side drives the decode-stage inputs; the slave side is the assist unit.
interface decode_assist_unit_if;
    logic [1:0]  ext_op;
    logic [15:0] imm;
    logic [31:0] ext_out;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        iseq;
    logic        islt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        imm_as_dec;
    logic        flush;
    logic [3:0]  mnem;
    logic [4:0]  dis_rs;
    logic [4:0]  dis_rt;
    logic [4:0]  dis_rd;
    logic [4:0]  dis_shamt;
    logic [31:0] dis_imm;
    logic [31:0] dis_target;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;
    logic [3:0]  trace_mnem;

    modport master (
        output ext_op, imm, cmp_a, cmp_b, pc, instr, imm_as_dec, flush,
        input  ext_out, iseq, islt, mnem, dis_rs, dis_rt, dis_rd, dis_shamt,
               dis_imm, dis_target, trace_pc, trace_instr, trace_mnem
    );

    modport slave (
        input  ext_op, imm, cmp_a, cmp_b, pc, instr, imm_as_dec, flush,
        output ext_out, iseq, islt, mnem, dis_rs, dis_rt, dis_rd, dis_shamt,
               dis_imm, dis_target, trace_pc, trace_instr, trace_mnem
    );
endinterface

// File: rtl/decode_assist_unit.sv
// Decode-stage helper: immediate extender, branch comparator, instruction disassembler
// and a one-entry PC/instruction trace register.
module decode_assist_unit (
    input logic                 clk,
    input logic                 reset,
    decode_assist_unit_if.slave bus
);
    localparam logic [3:0] MnUnknown = 4'd0;
    localparam logic [3:0] MnNop     = 4'd1;
    localparam logic [3:0] MnAddu    = 4'd2;
    localparam logic [3:0] MnSubu    = 4'd3;
    localparam logic [3:0] MnJr      = 4'd4;
    localparam logic [3:0] MnJalr    = 4'd5;
    localparam logic [3:0] MnAddi    = 4'd6;
    localparam logic [3:0] MnOri     = 4'd7;
    localparam logic [3:0] MnLui     = 4'd8;
    localparam logic [3:0] MnLw      = 4'd9;
    localparam logic [3:0] MnSw      = 4'd10;
    localparam logic [3:0] MnBeq     = 4'd11;
    localparam logic [3:0] MnJ       = 4'd12;
    localparam logic [3:0] MnJal     = 4'd13;

    logic [5:0]  opField;
    logic [5:0]  fnField;
    logic [3:0]  mnemCode;
    logic [31:0] instrSext;
    logic        useSigned;
    logic [31:0] tracePcQ;
    logic [31:0] traceInstrQ;
    logic [3:0]  traceMnemQ;

    // Immediate extender
    always_comb begin
        unique case (bus.ext_op)
            2'd1:    bus.ext_out = {{16{bus.imm[15]}}, bus.imm};
            2'd2:    bus.ext_out = {bus.imm, 16'h0000};
            default: bus.ext_out = {16'h0000, bus.imm};
        endcase
    end

    assign bus.iseq = (bus.cmp_a == bus.cmp_b);
    assign bus.islt = ($signed(bus.cmp_a) < $signed(bus.cmp_b));

    assign opField = bus.instr[31:26];
    assign fnField = bus.instr[5:0];

    // All-zero word is NOP before the op 0 function decode gets a look
    always_comb begin
        mnemCode = MnUnknown;
        if (bus.instr == 32'h0000_0000) begin
            mnemCode = MnNop;
        end else begin
            case (opField)
                6'h00: begin
                    case (fnField)
                        6'h21:   mnemCode = MnAddu;
                        6'h23:   mnemCode = MnSubu;
                        6'h08:   mnemCode = MnJr;
                        6'h09:   mnemCode = MnJalr;
                        default: mnemCode = MnUnknown;
                    endcase
                end
                6'h08:   mnemCode = MnAddi;
                6'h0D:   mnemCode = MnOri;
                6'h0F:   mnemCode = MnLui;
                6'h23:   mnemCode = MnLw;
                6'h2B:   mnemCode = MnSw;
                6'h04:   mnemCode = MnBeq;
                6'h02:   mnemCode = MnJ;
                6'h03:   mnemCode = MnJal;
                default: mnemCode = MnUnknown;
            endcase
        end
    end

    assign bus.mnem      = mnemCode;
    assign bus.dis_rs    = bus.instr[25:21];
    assign bus.dis_rt    = bus.instr[20:16];
    assign bus.dis_rd    = bus.instr[15:11];
    assign bus.dis_shamt = bus.instr[10:6];

    assign instrSext = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign useSigned = bus.imm_as_dec &&
                       (mnemCode inside {MnAddi, MnLw, MnSw, MnBeq});
    assign bus.dis_imm = useSigned ? instrSext : {16'h0000, bus.instr[15:0]};

    always_comb begin
        bus.dis_target = 32'h0000_0000;
        if (mnemCode == MnJ || mnemCode == MnJal) begin
            bus.dis_target = {bus.pc[31:28], bus.instr[25:0], 2'b00};
        end else if (mnemCode == MnBeq) begin
            bus.dis_target = bus.pc + 32'd4 + {instrSext[29:0], 2'b00};
        end
    end

    // Flush leaves the PC so the bubble is still attributable to its slot
    always_ff @(posedge clk) begin
        if (reset) begin
            tracePcQ    <= 32'h0000_0000;
            traceInstrQ <= 32'h0000_0000;
            traceMnemQ  <= MnUnknown;
        end else if (bus.flush) begin
            traceInstrQ <= 32'h0000_0000;
            traceMnemQ  <= MnUnknown;
        end else begin
            tracePcQ    <= bus.pc;
            traceInstrQ <= bus.instr;
            traceMnemQ  <= mnemCode;
        end
    end

    assign bus.trace_pc    = tracePcQ;
    assign bus.trace_instr = traceInstrQ;
    assign bus.trace_mnem  = traceMnemQ;
endmodule

// File: tb/tb_decode_assist_unit.sv
// Self-checking bench for decode_assist_unit: directed vector table, randomized run
// against a behavioural model, and hand-written trace-register sequences.
module tb_decode_assist_unit;
    logic clk = 1'b0;
    logic reset;
    int   passCount = 0;
    int   totalCount = 0;

    decode_assist_unit_if bus ();

    decode_assist_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  extOp;
        logic [15:0] imm;
        logic [31:0] cmpA;
        logic [31:0] cmpB;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        immAsDec;
        logic [31:0] expExt;
        logic        expEq;
        logic        expLt;
        logic [3:0]  expMnem;
        logic [31:0] expImm;
        logic [31:0] expTarget;
    } vec_t;

    vec_t vecs[10];

    logic [5:0] opTab[8]  = '{6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [3:0] opCode[8] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
    logic [5:0] fnTab[4]  = '{6'h21, 6'h23, 6'h08, 6'h09};
    logic [3:0] fnCode[4] = '{4'd2, 4'd3, 4'd4, 4'd5};

    function automatic logic [3:0] refMnem(logic [31:0] ins);
        if (ins == 32'd0) return 4'd1;
        if (ins[31:26] == 6'd0) begin
            for (int k = 0; k < 4; k++) if (ins[5:0] == fnTab[k]) return fnCode[k];
            return 4'd0;
        end
        for (int k = 0; k < 8; k++) if (ins[31:26] == opTab[k]) return opCode[k];
        return 4'd0;
    endfunction

    function automatic logic [31:0] refExt(logic [1:0] op, logic [15:0] v);
        int s;
        s = $signed(v);
        if (op == 2'd1) return 32'(s);
        if (op == 2'd2) return 32'(v) << 16;
        return 32'(v);
    endfunction

    function automatic logic [31:0] refImm(logic [31:0] ins, logic dec);
        int s;
        logic [3:0] m;
        s = $signed(ins[15:0]);
        m = refMnem(ins);
        if (dec && (m == 4'd6 || m == 4'd9 || m == 4'd10 || m == 4'd11)) return 32'(s);
        return 32'(ins[15:0]);
    endfunction

    function automatic logic [31:0] refTarget(logic [31:0] p, logic [31:0] ins);
        int s;
        logic [3:0] m;
        s = $signed(ins[15:0]);
        m = refMnem(ins);
        if (m == 4'd12 || m == 4'd13) return {p[31:28], ins[25:0], 2'b00};
        if (m == 4'd11) return p + 32'd4 + 32'(s * 4);
        return 32'd0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Trace model: one-entry history of the inputs seen at each rising edge
    logic [31:0] mPc, mInstr;
    logic [3:0]  mMnem;
    always @(posedge clk) begin
        if (reset) begin
            mPc <= 0; mInstr <= 0; mMnem <= 0;
        end else if (bus.flush) begin
            mInstr <= 0; mMnem <= 0;
        end else begin
            mPc <= bus.pc; mInstr <= bus.instr; mMnem <= refMnem(bus.instr);
        end
    end

    task automatic checkTraceModel(string tag);
        chk({tag, " trace_pc"}, bus.trace_pc, mPc);
        chk({tag, " trace_instr"}, bus.trace_instr, mInstr);
        chk({tag, " trace_mnem"}, 32'(bus.trace_mnem), 32'(mMnem));
    endtask

    task automatic drive(logic [31:0] p, logic [31:0] ins, logic fl, logic rs);
        bus.pc = p; bus.instr = ins; bus.flush = fl; reset = rs;
    endtask

    logic [31:0] rIns, rA, rB;

    initial begin
        vecs[0] = '{"beq_back", 2'd0, 16'h8001, 32'hFFFFFFFF, 32'h1, 32'h3000, 32'h1000FFFF,
                    1'b1, 32'h00008001, 1'b0, 1'b1, 4'd11, 32'hFFFFFFFF, 32'h00003000};
        vecs[1] = '{"jal", 2'd1, 16'h8001, 32'h5, 32'h5, 32'h3000, 32'h0C000C05,
                    1'b1, 32'hFFFF8001, 1'b1, 1'b0, 4'd13, 32'h00000C05, 32'h00003014};
        vecs[2] = '{"lw_dec", 2'd2, 16'h8001, 32'h1, 32'h80000000, 32'h3000, 32'h8C08FFFC,
                    1'b1, 32'h80010000, 1'b0, 1'b0, 4'd9, 32'hFFFFFFFC, 32'h0};
        vecs[3] = '{"lw_hex", 2'd3, 16'h8001, 32'h0, 32'h0, 32'h3000, 32'h8C08FFFC,
                    1'b0, 32'h00008001, 1'b1, 1'b0, 4'd9, 32'h0000FFFC, 32'h0};
        vecs[4] = '{"nop", 2'd0, 16'h0000, 32'h80000000, 32'h7FFFFFFF, 32'h3000, 32'h0,
                    1'b1, 32'h0, 1'b0, 1'b1, 4'd1, 32'h0, 32'h0};
        vecs[5] = '{"unknown", 2'd1, 16'h7FFF, 32'h7FFFFFFF, 32'h80000000, 32'h3000,
                    32'h0000003F, 1'b1, 32'h00007FFF, 1'b0, 1'b0, 4'd0, 32'h3F, 32'h0};
        vecs[6] = '{"j", 2'd2, 16'hFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hF0000000,
                    32'h08000010, 1'b1, 32'hFFFF0000, 1'b0, 1'b1, 4'd12, 32'h10, 32'hF0000040};
        vecs[7] = '{"addu", 2'd1, 16'h8000, 32'h3, 32'h3, 32'h0, 32'h00221821,
                    1'b1, 32'hFFFF8000, 1'b1, 1'b0, 4'd2, 32'h1821, 32'h0};
        vecs[8] = '{"ori", 2'd0, 16'hFFFF, 32'h0, 32'h1, 32'h0, 32'h3401FFFF,
                    1'b1, 32'h0000FFFF, 1'b0, 1'b1, 4'd7, 32'h0000FFFF, 32'h0};
        vecs[9] = '{"beq_wrap", 2'd3, 16'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC,
                    32'h10000001, 1'b0, 32'h00001234, 1'b1, 1'b0, 4'd11, 32'h1, 32'h4};

        bus.ext_op = 0; bus.imm = 0; bus.cmp_a = 0; bus.cmp_b = 0; bus.imm_as_dec = 0;
        drive(32'h1234, 32'h8C08FFFC, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("reset trace_pc", bus.trace_pc, 32'h0);
        chk("reset trace_instr", bus.trace_instr, 32'h0);
        chk("reset trace_mnem", 32'(bus.trace_mnem), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.ext_op = vecs[i].extOp; bus.imm = vecs[i].imm;
            bus.cmp_a = vecs[i].cmpA; bus.cmp_b = vecs[i].cmpB;
            bus.pc = vecs[i].pc; bus.instr = vecs[i].instr; bus.imm_as_dec = vecs[i].immAsDec;
            #1;
            chk({vecs[i].name, " ext_out"}, bus.ext_out, vecs[i].expExt);
            chk({vecs[i].name, " iseq"}, 32'(bus.iseq), 32'(vecs[i].expEq));
            chk({vecs[i].name, " islt"}, 32'(bus.islt), 32'(vecs[i].expLt));
            chk({vecs[i].name, " mnem"}, 32'(bus.mnem), 32'(vecs[i].expMnem));
            chk({vecs[i].name, " dis_imm"}, bus.dis_imm, vecs[i].expImm);
            chk({vecs[i].name, " dis_target"}, bus.dis_target, vecs[i].expTarget);
            @(negedge clk);
        end

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 15);
            rIns = $urandom;
            if (r == 0) rIns = 32'd0;
            else if (r < 6) begin
                rIns[31:26] = 6'd0;
                if (r < 5) rIns[5:0] = fnTab[r - 1];
            end else if (r < 13) rIns[31:26] = opTab[$urandom_range(0, 7)];
            rA = $urandom; rB = ($urandom_range(0, 3) == 0) ? rA : $urandom;
            bus.ext_op = 2'($urandom); bus.imm = 16'($urandom);
            bus.cmp_a = rA; bus.cmp_b = rB; bus.imm_as_dec = 1'($urandom);
            drive($urandom, rIns, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            #1;
            chk("rnd ext_out", bus.ext_out, refExt(bus.ext_op, bus.imm));
            chk("rnd iseq", 32'(bus.iseq), 32'(rA == rB));
            chk("rnd islt", 32'(bus.islt), 32'(int'(rA) < int'(rB)));
            chk("rnd mnem", 32'(bus.mnem), 32'(refMnem(rIns)));
            chk("rnd fields", {12'd0, bus.dis_rs, bus.dis_rt, bus.dis_rd, bus.dis_shamt},
                {12'd0, rIns[25:6]});
            chk("rnd dis_imm", bus.dis_imm, refImm(rIns, bus.imm_as_dec));
            chk("rnd dis_target", bus.dis_target, refTarget(bus.pc, rIns));
            @(posedge clk); #1;
            checkTraceModel("rnd");
            @(negedge clk);
        end

        // Hand sequences: load, flush bubble, reset, and reset beating flush
        drive(32'h3004, 32'h34010001, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("seq load trace_pc", bus.trace_pc, 32'h3004);
        chk("seq load trace_instr", bus.trace_instr, 32'h34010001);
        chk("seq load trace_mnem", 32'(bus.trace_mnem), 32'd7);
        @(negedge clk);
        drive(32'h3008, 32'h8C08FFFC, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("seq flush trace_pc", bus.trace_pc, 32'h3004);
        chk("seq flush trace_instr", bus.trace_instr, 32'h0);
        chk("seq flush trace_mnem", 32'(bus.trace_mnem), 32'd0);
        @(negedge clk);
        drive(32'h300C, 32'h0C000C05, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("seq reload trace_mnem", 32'(bus.trace_mnem), 32'd13);
        @(negedge clk);
        drive(32'h3010, 32'h34010001, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("seq rst+flush trace_pc", bus.trace_pc, 32'h0);
        chk("seq rst+flush trace_instr", bus.trace_instr, 32'h0);
        chk("seq rst+flush trace_mnem", 32'(bus.trace_mnem), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
